// File: rtl/universal_reg_pkg.sv
// -----------------------------------------------------------------------------
// universal_reg_pkg
// Shared types for the universal register: the opcode encoding seen on the
// 'op' port and the two-state control FSM. A small helper identifies the
// multi-cycle shift/rotate opcodes so the top and the shifter agree on them.
// Optional feature macro used by the design: UNIVERSAL_REG_FLAGS_EN
// -----------------------------------------------------------------------------
package universal_reg_pkg;

   // Opcode encoding of the 3-bit 'op' port
   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_CLR = 3'd1,
      OP_LD  = 3'd2,
      OP_INC = 3'd3,
      OP_DEC = 3'd4,
      OP_SHR = 3'd5,
      OP_SHL = 3'd6,
      OP_ROR = 3'd7
   } opcode_e;

   // IDLE accepts operations, SHIFT walks a multi-cycle shift one bit per edge
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // True for the opcodes that take one cycle per shifted bit
   function automatic logic isShiftOp(opcode_e opCode);
      return (opCode == OP_SHR) || (opCode == OP_SHL) || (opCode == OP_ROR);
   endfunction

endpackage

// File: rtl/universal_reg_shifter.sv
// -----------------------------------------------------------------------------
// universal_reg_shifter
// Purely combinational one-bit step of the shift/rotate datapath.
// Ports:
//   data_i    current register value
//   op_i      shift opcode (SHR, SHL, ROR); anything else passes data through
//   fill_i    bit inserted by SHR (at MSB) and SHL (at LSB)
//   data_o    value after one step
//   outBit_o  the bit that left the register on this step
// -----------------------------------------------------------------------------
module universal_reg_shifter
   import universal_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  opcode_e               op_i,
   input  logic                  fill_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  outBit_o
);

   // One-bit step; ROR feeds the LSB back into the MSB so nothing is lost
   always_comb begin
      data_o   = data_i;
      outBit_o = 1'b0;
      unique case (op_i)
         OP_SHR: begin
            data_o   = {fill_i, data_i[DATA_WIDTH-1:1]};
            outBit_o = data_i[0];
         end
         OP_SHL: begin
            data_o   = {data_i[DATA_WIDTH-2:0], fill_i};
            outBit_o = data_i[DATA_WIDTH-1];
         end
         OP_ROR: begin
            data_o   = {data_i[0], data_i[DATA_WIDTH-1:1]};
            outBit_o = data_i[0];
         end
         default: begin
            data_o   = data_i;
            outBit_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_reg.sv
// -----------------------------------------------------------------------------
// universal_reg
// A DATA_WIDTH-bit register with clear, load, increment, decrement and
// multi-cycle shift-right / shift-left / rotate-right operations.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   op_valid/ready  operation handshake; ready is high only in IDLE
//   op, in          opcode and load data
//   amt, fill       shift bit count (clamped to DATA_WIDTH) and fill bit
//   flush           synchronous abort-and-clear
//   out             register value
//   done            one-cycle pulse after the edge that completes an operation
//   zero/neg/carry  status flags
// Optional feature: define UNIVERSAL_REG_FLAGS_EN to build the status flags;
// without it the flag ports exist but are tied low.
// -----------------------------------------------------------------------------
module universal_reg
   import universal_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   localparam int AMT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic [AMT_WIDTH-1:0]  amt,
   input  logic                  fill,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  done,
   output logic                  zero,
   output logic                  neg,
   output logic                  carry
);

   localparam logic [AMT_WIDTH-1:0] MaxAmt = AMT_WIDTH'(DATA_WIDTH);

   state_e                  state_q;
   opcode_e                 shiftOp_q;
   logic [AMT_WIDTH-1:0]    count_q;
   logic                    fill_q;
   logic [DATA_WIDTH-1:0]   out_q;
   logic                    done_q;

   opcode_e                 opIn;
   logic [AMT_WIDTH-1:0]    count_d;
   logic [DATA_WIDTH-1:0]   shiftData;

   assign opIn    = opcode_e'(op);
   assign count_d = (amt > MaxAmt) ? MaxAmt : amt;

   // The shifter always works on the latched opcode/fill, so changes on the
   // op/amt/fill ports during SHIFT cannot disturb an operation in flight
`ifdef UNIVERSAL_REG_FLAGS_EN
   logic carry_q;
   logic shiftBit;

   universal_reg_shifter #(.DATA_WIDTH(DATA_WIDTH)) uShifter (
      .data_i   (out_q),
      .op_i     (shiftOp_q),
      .fill_i   (fill_q),
      .data_o   (shiftData),
      .outBit_o (shiftBit)
   );
`else
   universal_reg_shifter #(.DATA_WIDTH(DATA_WIDTH)) uShifter (
      .data_i   (out_q),
      .op_i     (shiftOp_q),
      .fill_i   (fill_q),
      .data_o   (shiftData),
      .outBit_o ()
   );
`endif

   // Control FSM and datapath registers. done is a registered pulse that is
   // cleared every cycle unless the current edge completes an operation.
   // A shift is accepted without moving any bit; each following edge in
   // SHIFT moves one bit, and the edge that sees count_q==1 is the last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shiftOp_q <= OP_NOP;
         count_q   <= '0;
         fill_q    <= 1'b0;
         out_q     <= '0;
         done_q    <= 1'b0;
`ifdef UNIVERSAL_REG_FLAGS_EN
         carry_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (flush) begin
                  out_q <= '0;
`ifdef UNIVERSAL_REG_FLAGS_EN
                  carry_q <= 1'b0;
`endif
               end else if (op_valid) begin
                  if (isShiftOp(opIn) && (amt != '0)) begin
                     state_q   <= ST_SHIFT;
                     shiftOp_q <= opIn;
                     count_q   <= count_d;
                     fill_q    <= fill;
                  end else begin
                     done_q <= 1'b1;
                     unique case (opIn)
                        OP_CLR: begin
                           out_q <= '0;
`ifdef UNIVERSAL_REG_FLAGS_EN
                           carry_q <= 1'b0;
`endif
                        end
                        OP_LD: begin
                           out_q <= in;
`ifdef UNIVERSAL_REG_FLAGS_EN
                           carry_q <= 1'b0;
`endif
                        end
                        OP_INC: begin
                           out_q <= out_q + DATA_WIDTH'(1);
`ifdef UNIVERSAL_REG_FLAGS_EN
                           carry_q <= &out_q;
`endif
                        end
                        OP_DEC: begin
                           out_q <= out_q - DATA_WIDTH'(1);
`ifdef UNIVERSAL_REG_FLAGS_EN
                           carry_q <= (out_q == '0);
`endif
                        end
                        default: begin
                           out_q <= out_q;
                        end
                     endcase
                  end
               end
            end
            ST_SHIFT: begin
               if (flush) begin
                  out_q   <= '0;
                  state_q <= ST_IDLE;
                  count_q <= '0;
`ifdef UNIVERSAL_REG_FLAGS_EN
                  carry_q <= 1'b0;
`endif
               end else begin
                  out_q   <= shiftData;
                  count_q <= count_q - AMT_WIDTH'(1);
`ifdef UNIVERSAL_REG_FLAGS_EN
                  carry_q <= shiftBit;
`endif
                  if (count_q == AMT_WIDTH'(1)) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Ready follows the state register, so reset raises it immediately
   assign op_ready = (state_q == ST_IDLE);
   assign out      = out_q;
   assign done     = done_q;

   // Status flags derived from the register value and the carry register
`ifdef UNIVERSAL_REG_FLAGS_EN
   assign zero  = (out_q == '0);
   assign neg   = out_q[DATA_WIDTH-1];
   assign carry = carry_q;
`else
   assign zero  = 1'b0;
   assign neg   = 1'b0;
   assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_universal_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_reg
// Directed test of universal_reg at DATA_WIDTH=16: a table of single-cycle
// operations with hand-computed results, then hand-written sequences for the
// multi-cycle shifts, flush during SHIFT and reset during SHIFT.
// Flag expectations collapse to 0 when UNIVERSAL_REG_FLAGS_EN is undefined.
// -----------------------------------------------------------------------------
module tb_universal_reg;

   localparam int W = 16;
   localparam int A = 5;

`ifdef UNIVERSAL_REG_FLAGS_EN
   localparam logic FlagsOn = 1'b1;
`else
   localparam logic FlagsOn = 1'b0;
`endif

   localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, LD = 3'd2, INC = 3'd3,
                          DEC = 3'd4, SHR = 3'd5, SHL = 3'd6, ROR = 3'd7;

   logic          clk;
   logic          rst;
   logic          opValid;
   logic          opReady;
   logic [2:0]    opCode;
   logic [W-1:0]  dataIn;
   logic [A-1:0]  amtIn;
   logic          fillIn;
   logic          flushIn;
   logic [W-1:0]  dataOut;
   logic          doneOut;
   logic          zeroOut;
   logic          negOut;
   logic          carryOut;

   int checks;
   int failures;

   universal_reg #(.DATA_WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (opValid),
      .op_ready (opReady),
      .op       (opCode),
      .in       (dataIn),
      .amt      (amtIn),
      .fill     (fillIn),
      .flush    (flushIn),
      .out      (dataOut),
      .done     (doneOut),
      .zero     (zeroOut),
      .neg      (negOut),
      .carry    (carryOut)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic          valid;
      logic [2:0]    op;
      logic [W-1:0]  din;
      logic [A-1:0]  amt;
      logic          fill;
      logic          flush;
      logic [W-1:0]  expOut;
      logic          expDone;
      logic          expZero;
      logic          expNeg;
      logic          expCarry;
   } vec_t;

   vec_t vecs[$];

   // Flags read back as 0 when the flag logic is not built
   function automatic logic fl(input logic v);
      return v & FlagsOn;
   endfunction

   // Compare one value and record the result
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drive one operation at the falling edge and wait until just after the rising edge
   task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [W-1:0] din,
                                input logic [A-1:0] amt, input logic fill, input logic flush);
      @(negedge clk);
      opValid = valid;
      opCode  = op;
      dataIn  = din;
      amtIn   = amt;
      fillIn  = fill;
      flushIn = flush;
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic valid, input logic [2:0] op, input logic [W-1:0] din,
                         input logic [A-1:0] amt, input logic flush, input logic [W-1:0] expOut,
                         input logic expDone, input logic z, input logic n, input logic c);
      vec_t v;
      v.valid = valid; v.op = op; v.din = din; v.amt = amt; v.fill = 1'b0; v.flush = flush;
      v.expOut = expOut; v.expDone = expDone; v.expZero = z; v.expNeg = n; v.expCarry = c;
      vecs.push_back(v);
   endtask

   // Run a multi-cycle shift: count busy cycles, scramble inputs while busy,
   // then check the single done pulse, the result and the carry
   task automatic doShift(input string name, input logic [2:0] op, input logic [A-1:0] amt,
                          input logic fill, input int expCycles, input logic [W-1:0] expOut,
                          input logic expCarry);
      int busy;
      int earlyDone;
      busy = 0;
      earlyDone = 0;
      applyStimulus(1'b1, op, 16'h0000, amt, fill, 1'b0);
      while (!opReady && busy < 40) begin
         busy++;
         if (doneOut) earlyDone++;
         @(negedge clk);
         opValid = 1'b1;
         opCode  = LD;
         dataIn  = 16'hDEAD;
         amtIn   = 5'd2;
         fillIn  = ~fillIn;
         @(posedge clk);
         #1;
      end
      checkOutput({name, " busy cycles"}, busy, expCycles);
      checkOutput({name, " early done"}, earlyDone, 0);
      checkOutput({name, " done pulse"}, {31'b0, doneOut}, 1);
      checkOutput({name, " out"}, {16'b0, dataOut}, {16'b0, expOut});
      checkOutput({name, " carry"}, {31'b0, carryOut}, {31'b0, fl(expCarry)});
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b0);
      checkOutput({name, " done drops"}, {31'b0, doneOut}, 0);
      checkOutput({name, " out held"}, {16'b0, dataOut}, {16'b0, expOut});
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      opValid  = 1'b0;
      opCode   = NOP;
      dataIn   = '0;
      amtIn    = '0;
      fillIn   = 1'b0;
      flushIn  = 1'b0;

      // Single-cycle table: valid, op, din, amt, flush, out, done, zero, neg, carry
      addVec(1, NOP, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0);
      addVec(1, LD,  16'h00FF, 0, 0, 16'h00FF, 1, 0, 0, 0);
      addVec(1, INC, 16'h0000, 0, 0, 16'h0100, 1, 0, 0, 0);
      addVec(0, INC, 16'h0000, 0, 0, 16'h0100, 0, 0, 0, 0);
      addVec(1, LD,  16'hFFFF, 0, 0, 16'hFFFF, 1, 0, 1, 0);
      addVec(1, INC, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 1);
      addVec(1, DEC, 16'h0000, 0, 0, 16'hFFFF, 1, 0, 1, 1);
      addVec(1, DEC, 16'h0000, 0, 0, 16'hFFFE, 1, 0, 1, 0);
      addVec(1, CLR, 16'h0000, 0, 0, 16'h0000, 1, 1, 0, 0);
      addVec(1, DEC, 16'h0000, 0, 0, 16'hFFFF, 1, 0, 1, 1);
      addVec(1, LD,  16'h1234, 0, 1, 16'h0000, 0, 1, 0, 0);
      addVec(1, LD,  16'h1234, 0, 0, 16'h1234, 1, 0, 0, 0);
      addVec(1, SHR, 16'h0000, 0, 0, 16'h1234, 1, 0, 0, 0);
      addVec(1, ROR, 16'h0000, 0, 0, 16'h1234, 1, 0, 0, 0);
      addVec(1, LD,  16'h7FFF, 0, 0, 16'h7FFF, 1, 0, 0, 0);
      addVec(1, INC, 16'h0000, 0, 0, 16'h8000, 1, 0, 1, 0);
      addVec(1, DEC, 16'h0000, 0, 0, 16'h7FFF, 1, 0, 0, 0);

      // Reset state while reset is held
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out",   {16'b0, dataOut}, 0);
      checkOutput("reset ready", {31'b0, opReady}, 1);
      checkOutput("reset done",  {31'b0, doneOut}, 0);
      checkOutput("reset zero",  {31'b0, zeroOut}, {31'b0, fl(1'b1)});
      checkOutput("reset neg",   {31'b0, negOut}, 0);
      checkOutput("reset carry", {31'b0, carryOut}, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].din, vecs[i].amt, vecs[i].fill, vecs[i].flush);
         checkOutput($sformatf("vec%0d out", i),   {16'b0, dataOut}, {16'b0, vecs[i].expOut});
         checkOutput($sformatf("vec%0d done", i),  {31'b0, doneOut}, {31'b0, vecs[i].expDone});
         checkOutput($sformatf("vec%0d ready", i), {31'b0, opReady}, 1);
         checkOutput($sformatf("vec%0d zero", i),  {31'b0, zeroOut}, {31'b0, fl(vecs[i].expZero)});
         checkOutput($sformatf("vec%0d neg", i),   {31'b0, negOut}, {31'b0, fl(vecs[i].expNeg)});
         checkOutput($sformatf("vec%0d carry", i), {31'b0, carryOut}, {31'b0, fl(vecs[i].expCarry)});
      end

      // SHR by 3 with fill=1: 0x8001 -> 0xC000 -> 0xE000 -> 0xF000, last bit out 0
      applyStimulus(1'b1, LD, 16'h8001, 5'd0, 1'b0, 1'b0);
      doShift("shr3", SHR, 5'd3, 1'b1, 3, 16'hF000, 1'b0);

      // SHL by 2 with fill=1: 0xF00F -> 0xE01F -> 0xC03F, both bits out were 1
      applyStimulus(1'b1, LD, 16'hF00F, 5'd0, 1'b0, 1'b0);
      doShift("shl2", SHL, 5'd2, 1'b1, 2, 16'hC03F, 1'b1);

      // ROR by 1 then by 20 (clamped to 16 cycles, full rotation)
      applyStimulus(1'b1, LD, 16'h0001, 5'd0, 1'b0, 1'b0);
      doShift("ror1", ROR, 5'd1, 1'b0, 1, 16'h8000, 1'b1);
      doShift("ror20", ROR, 5'd20, 1'b0, 16, 16'h8000, 1'b1);

      // Flush on the third SHIFT cycle of SHL by 8
      applyStimulus(1'b1, LD, 16'h00FF, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, SHL, 16'h0000, 5'd8, 1'b0, 1'b0);
      checkOutput("flush accept ready", {31'b0, opReady}, 0);
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b0);
      checkOutput("flush pre out", {16'b0, dataOut}, 32'h03FC);
      checkOutput("flush pre ready", {31'b0, opReady}, 0);
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b1);
      checkOutput("flush out",   {16'b0, dataOut}, 0);
      checkOutput("flush ready", {31'b0, opReady}, 1);
      checkOutput("flush done",  {31'b0, doneOut}, 0);
      checkOutput("flush carry", {31'b0, carryOut}, 0);
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b0);
      checkOutput("flush after done", {31'b0, doneOut}, 0);
      checkOutput("flush after out",  {16'b0, dataOut}, 0);

      // Reset asserted in the middle of SHL by 8
      applyStimulus(1'b1, LD, 16'h00FF, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b1, SHL, 16'h0000, 5'd8, 1'b1, 1'b0);
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, NOP, 16'h0000, 5'd0, 1'b0, 1'b0);
      checkOutput("rst pre out", {16'b0, dataOut}, 32'h03FF);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst mid out",   {16'b0, dataOut}, 0);
      checkOutput("rst mid ready", {31'b0, opReady}, 1);
      checkOutput("rst mid done",  {31'b0, doneOut}, 0);
      checkOutput("rst mid carry", {31'b0, carryOut}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("rst after done%0d", k), {31'b0, doneOut}, 0);
         checkOutput($sformatf("rst after out%0d", k), {16'b0, dataOut}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, register width (>=2).
REQ-002 SHALL have localparam AMT_WIDTH = clog2(DATA_WIDTH)+1, the shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port op_valid  input  1  operation request.
REQ-006 SHALL have port op_ready  output  1  block can accept an operation.
REQ-007 SHALL have port op  input  3  opcode: 0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 ROR.
REQ-008 SHALL have port in  input  DATA_WIDTH  load data.
REQ-009 SHALL have port amt  input  AMT_WIDTH  shift/rotate bit count.
REQ-010 SHALL have port fill  input  1  bit shifted in by SHR/SHL.
REQ-011 SHALL have port flush  input  1  synchronous abort-and-clear.
REQ-012 SHALL have port out  output  DATA_WIDTH  register value.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have ports zero, neg, carry  output  1 each  status flags.

Function
REQ-015 SHALL accept an operation on a rising edge with op_valid && op_ready.
REQ-016 SHALL implement FSM states IDLE and SHIFT; op_ready = (state == IDLE).
REQ-017 SHALL apply CLR/LD/INC/DEC on the accepting edge; NOP leaves out unchanged.
REQ-018 SHALL make INC/DEC wrap modulo 2^DATA_WIDTH.
REQ-019 SHALL assert done for exactly one cycle, the cycle after the edge completing the operation (NOP included).
REQ-020 SHALL, for SHR/SHL/ROR with amt>0, latch count=min(amt,DATA_WIDTH) and fill, enter SHIFT, shift one bit per edge, and return to IDLE on the count-th edge.
REQ-021 SHALL make SHR insert fill at MSB, SHL insert fill at LSB, ROR move LSB to MSB.
REQ-022 SHALL treat amt=0 shifts as single-cycle with out unchanged.
REQ-023 SHALL, on flush in IDLE, clear out and ignore op that cycle; flush in SHIFT clears out, returns to IDLE, suppresses done.
REQ-024 SHALL ignore op/amt/fill changes while in SHIFT.

Reset
REQ-025 SHALL, while rst is high, force out=0, state=IDLE, count=0, done=0, carry=0, immediately, including mid-shift.
REQ-026 SHALL present op_ready=1, zero=1 (when flags enabled), neg=0 after reset.

Configuration
REQ-027 SHALL compile status flags only when UNIVERSAL_REG_FLAGS_EN is defined: zero=(out==0), neg=out MSB, carry registered = INC wrap from all-ones, DEC wrap from zero, last bit shifted/rotated out; CLR/LD/flush clear carry.
REQ-028 SHALL, without UNIVERSAL_REG_FLAGS_EN, keep zero/neg/carry ports, tied to 0.

Structure
REQ-029 SHALL place opcode enum and FSM state typedef in package universal_reg_pkg.
REQ-030 SHALL use one combinational sub-module universal_reg_shifter (one-bit SHR/SHL/ROR step plus shifted-out bit).

Verification (DATA_WIDTH=16)
REQ-031 SHALL test LD 0x00FF then INC -> out 0x0100, done pulse one cycle after each edge.
REQ-032 SHALL test LD 0xFFFF, INC -> out 0x0000, carry=1, zero=1 (flags on); DEC -> 0xFFFF, carry=1, neg=1.
REQ-033 SHALL test LD 0x8001, SHR amt=3 fill=1 -> op_ready low 3 cycles, out 0xF000, carry=0, single done.
REQ-034 SHALL test LD 0x0001, ROR amt=1 -> 0x8000, carry=1; ROR amt=20 -> clamped to 16 cycles, out 0x8000.
REQ-035 SHALL test LD 0x00FF, SHL amt=8, flush on 3rd SHIFT cycle -> out 0x0000, op_ready next cycle, no done.
REQ-036 SHALL test rst asserted mid-SHIFT -> out 0x0000, op_ready=1 asynchronously, no done after release.
